// File: rtl/fifo_uart_tx.sv
// Drains 16-bit words from the SRAM FIFO and sends each as two 8N1 UART frames, high byte first.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit to every frame.
module fifo_uart_tx #(
  parameter int unsigned BAUD_DIV  = 434,
  parameter int unsigned DATA_SIZE = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 Empty,
  input  logic                 WrActive,
  input  logic [DATA_SIZE-1:0] Din,
  output logic                 Rd,
  output logic                 TxD,
  output logic                 Busy
);

  localparam int unsigned TimerW = $clog2(BAUD_DIV);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(BAUD_DIV - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e                 state_q;
  logic [TimerW-1:0]      timer_q;
  logic [2:0]             bit_idx_q;
  logic                   byte_sel_q;
  logic [DATA_SIZE-1:0]   word_q;
  logic [7:0]             cur_byte;
  logic                   bit_done;

  assign cur_byte = byte_sel_q ? word_q[7:0] : word_q[15:8];
  assign bit_done = (timer_q == TimerMax);

  // A pop during reset would be discarded along with the word, so hold it off.
  assign Rd = (state_q == StIdle) & Enable & ~Empty & ~WrActive & ~Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_sel_q <= 1'b0;
      word_q     <= '0;
      TxD        <= 1'b1;
      Busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Rd) begin
            word_q     <= Din;
            byte_sel_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= StStart;
            TxD        <= 1'b0;
            Busy       <= 1'b1;
          end
        end
        StStart: begin
          if (bit_done) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
            TxD       <= cur_byte[0];
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StData: begin
          if (bit_done) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state_q <= StParity;
              TxD     <= ^cur_byte;
`else
              state_q <= StStop;
              TxD     <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              TxD       <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        StParity: begin
          if (bit_done) begin
            timer_q <= '0;
            state_q <= StStop;
            TxD     <= 1'b1;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
`endif
        StStop: begin
          if (bit_done) begin
            timer_q <= '0;
            if (!byte_sel_q) begin
              // Second byte of the same word: no new pop.
              byte_sel_q <= 1'b1;
              state_q    <= StStart;
              TxD        <= 1'b0;
            end else begin
              state_q <= StIdle;
              Busy    <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized bench for fifo_uart_tx: a FIFO model feeds the DUT and a line-level model predicts
// TxD, Busy and Rd every clock.
module tb_fifo_uart_tx;

  localparam int unsigned BD = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned WordClks = 22 * BD;
`else
  localparam int unsigned WordClks = 20 * BD;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        Empty = 1'b1;
  logic        WrActive = 1'b0;
  logic [15:0] Din = 16'h0000;
  logic        Rd, TxD, Busy;

  fifo_uart_tx #(.BAUD_DIV(BD), .DATA_SIZE(16)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Enable   (Enable),
    .Empty    (Empty),
    .WrActive (WrActive),
    .Din      (Din),
    .Rd       (Rd),
    .TxD      (TxD),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [15:0] fifo_q[$];
  bit          exp_q[$];
  logic [15:0] last_pop = 16'h0000;
  logic        s_rd, s_txd, s_busy, e_rd, e_txd, e_busy;

  function automatic void push_bit(input bit b);
    for (int i = 0; i < BD; i++) exp_q.push_back(b);
  endfunction

  // Expected line levels for one whole word, one entry per clock.
  function automatic void push_word(input logic [15:0] w);
    logic [7:0] bv;
    for (int b = 0; b < 2; b++) begin
      bv = (b == 0) ? w[15:8] : w[7:0];
      push_bit(1'b0);
      for (int i = 0; i < 8; i++) push_bit(bv[i]);
`ifdef FIFO_UART_TX_PARITY_EN
      push_bit(($countones(bv) % 2) == 1);
`endif
      push_bit(1'b1);
    end
  endfunction

  // One clock: drive FIFO side, sample DUT and model mid-cycle, then advance both at the edge.
  task automatic step();
    Empty = (fifo_q.size() == 0);
    Din   = Empty ? 16'h0000 : fifo_q[0];
    #2;
    s_rd   = Rd;
    s_txd  = TxD;
    s_busy = Busy;
    e_rd   = !Reset && Enable && !Empty && !WrActive && (exp_q.size() == 0);
    e_txd  = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
    e_busy = (exp_q.size() != 0);
    @(posedge Clk);
    cyc++;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (s_rd === 1'b1 && !Empty) begin
      last_pop = fifo_q.pop_front();
      if (!Reset) push_word(last_pop);
    end
    if (Reset) exp_q.delete();
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    Reset  = 1'b0;
    Enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks += 3;
      if (s_txd !== 1'b1) begin
        errors++; $display("FAIL reset_txd cyc=%0d got=%b exp=1", cyc, s_txd);
      end
      if (s_busy !== 1'b0) begin
        errors++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", cyc, s_busy);
      end
      if (s_rd !== 1'b0) begin
        errors++; $display("FAIL reset_rd cyc=%0d got=%b exp=0", cyc, s_rd);
      end
    end
  endtask

  task automatic test_single_word();
    int rd_cnt = 0;
    int busy_cnt = 0;
    fifo_q.push_back(16'hA55A);
    for (int i = 0; i < WordClks + 20; i++) begin
      step();
      rd_cnt += (s_rd === 1'b1);
      busy_cnt += (s_busy === 1'b1);
      checks += 3;
      if (s_rd !== e_rd) begin
        errors++; $display("FAIL single_rd cyc=%0d got=%b exp=%b", cyc, s_rd, e_rd);
      end
      if (s_txd !== e_txd) begin
        errors++; $display("FAIL single_txd cyc=%0d got=%b exp=%b", cyc, s_txd, e_txd);
      end
      if (s_busy !== e_busy) begin
        errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy);
      end
    end
    checks += 2;
    if (rd_cnt != 1) begin
      errors++; $display("FAIL single_rd_count got=%0d exp=1", rd_cnt);
    end
    if (busy_cnt != WordClks) begin
      errors++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, WordClks);
    end
  endtask

  task automatic test_collision();
    fifo_q.push_back(16'($urandom));
    WrActive = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s_rd !== 1'b0) begin
        errors++; $display("FAIL collision_rd_blocked cyc=%0d got=%b exp=0", cyc, s_rd);
      end
    end
    WrActive = 1'b0;
    step();
    checks++;
    if (s_rd !== 1'b1) begin
      errors++; $display("FAIL collision_rd_retry cyc=%0d got=%b exp=1", cyc, s_rd);
    end
    for (int i = 0; i < WordClks + 5; i++) begin
      step();
      checks += 3;
      if (s_rd !== e_rd) begin
        errors++; $display("FAIL collision_rd cyc=%0d got=%b exp=%b", cyc, s_rd, e_rd);
      end
      if (s_txd !== e_txd) begin
        errors++; $display("FAIL collision_txd cyc=%0d got=%b exp=%b", cyc, s_txd, e_txd);
      end
      if (s_busy !== e_busy) begin
        errors++; $display("FAIL collision_busy cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pops[$];
    for (int i = 0; i < 3; i++) fifo_q.push_back(16'($urandom));
    for (int i = 0; i < 3 * (WordClks + 1) + 10; i++) begin
      step();
      if (s_rd === 1'b1) pops.push_back(cyc);
      checks += 2;
      if (s_txd !== e_txd) begin
        errors++; $display("FAIL b2b_txd cyc=%0d got=%b exp=%b", cyc, s_txd, e_txd);
      end
      if (s_busy !== e_busy) begin
        errors++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy);
      end
    end
    checks++;
    if (pops.size() != 3) begin
      errors++; $display("FAIL b2b_rd_count got=%0d exp=3", pops.size());
    end
    for (int i = 1; i < pops.size(); i++) begin
      checks++;
      if (pops[i] - pops[i-1] != int'(WordClks + 1)) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d exp=%0d", pops[i] - pops[i-1], WordClks + 1);
      end
    end
  endtask

  task automatic test_enable_drop();
    int rd_cnt = 0;
    fifo_q.push_back(16'($urandom));
    fifo_q.push_back(16'($urandom));
    step();
    checks++;
    if (s_rd !== 1'b1) begin
      errors++; $display("FAIL endrop_first_rd got=%b exp=1", s_rd);
    end
    Enable = 1'b0;
    for (int i = 0; i < WordClks + 20; i++) begin
      step();
      rd_cnt += (s_rd === 1'b1);
      checks += 2;
      if (s_txd !== e_txd) begin
        errors++; $display("FAIL endrop_txd cyc=%0d got=%b exp=%b", cyc, s_txd, e_txd);
      end
      if (s_busy !== e_busy) begin
        errors++; $display("FAIL endrop_busy cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy);
      end
    end
    checks += 2;
    if (rd_cnt != 0) begin
      errors++; $display("FAIL endrop_no_pop got=%0d exp=0", rd_cnt);
    end
    if (fifo_q.size() != 1) begin
      errors++; $display("FAIL endrop_fifo_left got=%0d exp=1", fifo_q.size());
    end
    Enable = 1'b1;
    for (int i = 0; i < WordClks + 5; i++) step();
    checks++;
    if (fifo_q.size() != 0) begin
      errors++; $display("FAIL endrop_drain got=%0d exp=0", fifo_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w2;
    w2 = 16'($urandom);
    fifo_q.push_back(16'($urandom));
    fifo_q.push_back(w2);
    step();
    for (int i = 0; i < 4 * BD + 1; i++) step();
    Reset = 1'b1;
    step();
    checks++;
    if (s_txd !== e_txd) begin
      errors++; $display("FAIL midrst_bit3 got=%b exp=%b", s_txd, e_txd);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks += 3;
      if (s_txd !== 1'b1) begin
        errors++; $display("FAIL midrst_txd cyc=%0d got=%b exp=1", cyc, s_txd);
      end
      if (s_busy !== 1'b0) begin
        errors++; $display("FAIL midrst_busy cyc=%0d got=%b exp=0", cyc, s_busy);
      end
      if (s_rd !== 1'b0) begin
        errors++; $display("FAIL midrst_rd cyc=%0d got=%b exp=0", cyc, s_rd);
      end
    end
    Reset = 1'b0;
    step();
    checks += 2;
    if (s_rd !== 1'b1) begin
      errors++; $display("FAIL midrst_repop got=%b exp=1", s_rd);
    end
    if (last_pop !== w2) begin
      errors++; $display("FAIL midrst_next_word got=%h exp=%h", last_pop, w2);
    end
    for (int i = 0; i < WordClks + 5; i++) begin
      step();
      checks += 2;
      if (s_txd !== e_txd) begin
        errors++; $display("FAIL midrst_txd2 cyc=%0d got=%b exp=%b", cyc, s_txd, e_txd);
      end
      if (s_busy !== e_busy) begin
        errors++; $display("FAIL midrst_busy2 cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) fifo_q.push_back(16'($urandom));
    for (int i = 0; i < 6 * (WordClks + 1) + 200; i++) begin
      WrActive = ($urandom_range(0, 9) < 3);
      Enable   = ($urandom_range(0, 9) != 0);
      step();
      checks += 3;
      if (s_rd !== e_rd) begin
        errors++; $display("FAIL rand_rd cyc=%0d got=%b exp=%b", cyc, s_rd, e_rd);
      end
      if (s_txd !== e_txd) begin
        errors++; $display("FAIL rand_txd cyc=%0d got=%b exp=%b", cyc, s_txd, e_txd);
      end
      if (s_busy !== e_busy) begin
        errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy);
      end
    end
    WrActive = 1'b0;
    Enable   = 1'b1;
    for (int i = 0; i < 2 * (WordClks + 1); i++) step();
    checks++;
    if (fifo_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain got fifo=%0d line=%0d exp=0", fifo_q.size(), exp_q.size());
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    bit tr[200];
    int p = -1;
    int busy_cnt = 0;
    fifo_q.push_back(16'h0701);
    for (int i = 0; i < WordClks + 20; i++) begin
      step();
      tr[i] = s_txd;
      busy_cnt += (s_busy === 1'b1);
      if (s_rd === 1'b1 && p < 0) p = i;
      checks++;
      if (s_txd !== e_txd) begin
        errors++; $display("FAIL parity_txd cyc=%0d got=%b exp=%b", cyc, s_txd, e_txd);
      end
    end
    checks += 3;
    if (p < 0 || tr[p + 1 + 9 * BD + 1] != 1'b1) begin
      errors++; $display("FAIL parity_hi got=%b exp=1", (p < 0) ? 1'b0 : tr[p + 1 + 9 * BD + 1]);
    end
    if (p < 0 || tr[p + 1 + 20 * BD + 1] != 1'b1) begin
      errors++; $display("FAIL parity_lo got=%b exp=1", (p < 0) ? 1'b0 : tr[p + 1 + 20 * BD + 1]);
    end
    if (busy_cnt != 88) begin
      errors++; $display("FAIL parity_word_len got=%0d exp=88", busy_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_collision();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    test_random();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
